gfx_texture_fetch: RTL

GFX_TEXTURE_FETCH -- requirements
Module: gfx_texture_fetch

---
 rtl/gfx_texture_fetch.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/gfx_texture_fetch.sv
// Texture fetch: turns a texel (x,y) request into a word read with a one-word cache.
// Latency: 3 cycles from accept to texel_valid_o on a hit or an out-of-range request; misses add the bus wait plus the release cycles.
// Backpressure: one request in flight; fetch_ready_o is low until the texel is taken, and texel_o is held while texel_ready_i is low.
module gfx_texture_fetch #(
   parameter int POINT_WIDTH = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [POINT_WIDTH-1:0] tex_x_i,
   input  logic [POINT_WIDTH-1:0] tex_y_i,
   input  logic                   fetch_valid_i,
   output logic                   fetch_ready_o,
   input  logic [31:0]            tex_base_i,
   input  logic [POINT_WIDTH-1:0] tex_width_i,
   input  logic [POINT_WIDTH-1:0] tex_height_i,
   input  logic [1:0]             color_depth_i,
   input  logic                   invalidate_i,
   output logic                   read_request_o,
   output logic [29:0]            texture_addr_o,
   output logic [3:0]             texture_sel_o,
   input  logic [31:0]            texture_dat_i,
   input  logic                   texture_data_ack_i,
   output logic [31:0]            texel_o,
   output logic                   texel_valid_o,
   input  logic                   texel_ready_i
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CALC    = 3'd1,
      S_LOOKUP  = 3'd2,
      S_READ    = 3'd3,
      S_RELEASE = 3'd4,
      S_OUT     = 3'd5
   } state_t;

   state_t state;
   state_t state_nxt;

   // Request snapshot, so later changes on the configuration inputs cannot disturb it.
   logic [POINT_WIDTH-1:0] x_q;
   logic [POINT_WIDTH-1:0] y_q;
   logic [POINT_WIDTH-1:0] width_q;
   logic [POINT_WIDTH-1:0] height_q;
   logic [31:0]            base_q;
   logic [1:0]             depth_q;
   logic [31:0]            byte_addr_q;

   // Single-word cache: the last word read from memory.
   logic        cache_vld;
   logic [29:0] cache_tag;
   logic [31:0] cache_word;

   logic        out_of_range;
   logic        cache_hit;
   logic        capture;
   logic [31:0] pixel_index;
   logic [31:0] byte_offset;
   logic [31:0] byte_addr_calc;

   // Byte lanes are big-endian: the lowest texel address sits in the top lane.
   function automatic logic [3:0] lane_sel(input logic [1:0] depth, input logic [1:0] lo);
      logic [3:0] sel;
      case (depth)
         2'b00:   sel = 4'b1000 >> lo;
         2'b01:   sel = lo[1] ? 4'b0011 : 4'b1100;
         default: sel = 4'b1111;
      endcase
      return sel;
   endfunction

   // Pull the addressed texel out of a word, right-aligned and zero-extended.
   function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                input logic [1:0]  depth,
                                                input logic [1:0]  lo);
      logic [31:0] texel;
      case (depth)
         2'b00: begin
            case (lo)
               2'b00:   texel = {24'd0, word[31:24]};
               2'b01:   texel = {24'd0, word[23:16]};
               2'b10:   texel = {24'd0, word[15:8]};
               default: texel = {24'd0, word[7:0]};
            endcase
         end
         2'b01:   texel = lo[1] ? {16'd0, word[15:0]} : {16'd0, word[31:16]};
         default: texel = word;
      endcase
      return texel;
   endfunction

   // Address arithmetic wraps modulo 2^32; a zero dimension makes every request out of range.
   always_comb begin
      pixel_index = 32'(y_q) * 32'(width_q) + 32'(x_q);
      case (depth_q)
         2'b00:   byte_offset = pixel_index;
         2'b01:   byte_offset = pixel_index << 1;
         default: byte_offset = pixel_index << 2;
      endcase
      byte_addr_calc = base_q + byte_offset;
      out_of_range   = (x_q >= width_q) || (y_q >= height_q);
      cache_hit      = cache_vld && (cache_tag == byte_addr_q[31:2]);
      capture        = (state == S_READ) && texture_data_ack_i;
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (fetch_valid_i) begin
               state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            state_nxt = S_LOOKUP;
         end
         S_LOOKUP: begin
            if (out_of_range || cache_hit) begin
               state_nxt = S_OUT;
            end else begin
               state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (texture_data_ack_i) begin
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            // The reader must see its ack drop before anything else happens.
            if (!texture_data_ack_i) begin
               state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            if (texel_ready_i) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Handshake outputs are decoded straight from the state, so reset drops them at once.
   always_comb begin
      fetch_ready_o  = (state == S_IDLE);
      read_request_o = (state == S_READ);
      texel_valid_o  = (state == S_OUT);
   end

   // Capture the request and its texture configuration on acceptance.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         x_q      <= '0;
         y_q      <= '0;
         width_q  <= '0;
         height_q <= '0;
         base_q   <= '0;
         depth_q  <= '0;
      end else if ((state == S_IDLE) && fetch_valid_i) begin
         x_q      <= tex_x_i;
         y_q      <= tex_y_i;
         width_q  <= tex_width_i;
         height_q <= tex_height_i;
         base_q   <= tex_base_i;
         depth_q  <= color_depth_i;
      end
   end

   // Register the texel byte address during CALC.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         byte_addr_q <= '0;
      end else if (state == S_CALC) begin
         byte_addr_q <= byte_addr_calc;
      end
   end

   // Set up the bus address and lanes on a miss; they stay put through READ.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         texture_addr_o <= '0;
         texture_sel_o  <= 4'b1111;
      end else if ((state == S_LOOKUP) && !out_of_range && !cache_hit) begin
         texture_addr_o <= byte_addr_q[31:2];
         texture_sel_o  <= lane_sel(depth_q, byte_addr_q[1:0]);
      end
   end

   // Load the result texel from the cache, from the bus, or zero when out of range.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         texel_o <= '0;
      end else if (state == S_LOOKUP) begin
         if (out_of_range) begin
            texel_o <= '0;
         end else if (cache_hit) begin
            texel_o <= lane_extract(cache_word, depth_q, byte_addr_q[1:0]);
         end
      end else if (capture) begin
         texel_o <= lane_extract(texture_dat_i, depth_q, byte_addr_q[1:0]);
      end
   end

   // Cache fill on the first ack; an invalidate on the same edge loses to the fill.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cache_vld  <= 1'b0;
         cache_tag  <= '0;
         cache_word <= '0;
      end else if (capture) begin
         cache_vld  <= 1'b1;
         cache_tag  <= byte_addr_q[31:2];
         cache_word <= texture_dat_i;
      end else if (invalidate_i) begin
         cache_vld  <= 1'b0;
      end
   end

endmodule
